alu_share_arbiter: RTL

Sequencer that time-shares the single combinational ALU between two requesters (N = 0, 1), e.g. the main datapath and an address/branch helper. It arbitrates round-robin, registers the winner's operands, drives the ALU for one execute cycle, captures result and flags, and holds the response until the owning requester accepts it. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that time-shares one combinational ALU between two
// requesters. A winning request is registered, executed for one cycle, and its
// result and flags are held until the owning requester accepts them.
module alu_share_arbiter #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,

  // Requester 0
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [3:0]             req0_control,
  input  logic [4:0]             req0_shmt,
  input  logic [WORD_LENGTH-1:0] req0_dataA,
  input  logic [WORD_LENGTH-1:0] req0_dataB,

  // Requester 1
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [3:0]             req1_control,
  input  logic [4:0]             req1_shmt,
  input  logic [WORD_LENGTH-1:0] req1_dataA,
  input  logic [WORD_LENGTH-1:0] req1_dataB,

  // Shared ALU
  output logic [3:0]             alu_control,
  output logic [4:0]             alu_shmt,
  output logic [WORD_LENGTH-1:0] alu_dataA,
  output logic [WORD_LENGTH-1:0] alu_dataB,
  input  logic [WORD_LENGTH-1:0] alu_dataC,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   alu_negative,

  // Response 0
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [WORD_LENGTH-1:0] rsp0_data,
  output logic [2:0]             rsp0_flags,

  // Response 1
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [WORD_LENGTH-1:0] rsp1_data,
  output logic [2:0]             rsp1_flags,

  // Status
  output logic                   busy,
  output logic                   grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_next;

  // Arbitration bookkeeping
  logic                   last_grant;
  logic                   winner;
  logic                   accept;
  logic                   rsp_taken;

  // Operand registers feeding the ALU
  logic [3:0]             op_control;
  logic [4:0]             op_shmt;
  logic [WORD_LENGTH-1:0] op_data_a;
  logic [WORD_LENGTH-1:0] op_data_b;

  // Result capture registers
  logic [WORD_LENGTH-1:0] res_data;
  logic [2:0]             res_flags;

  // Winner selection: on a tie the requester not granted last time wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else begin
      winner = req1_valid && !req0_valid;
    end
  end

  // Accept only from IDLE and never while reset is asserted.
  always_comb begin
    accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
    req0_ready = accept && !winner;
    req1_ready = accept && winner;
  end

  // Only the owning requester's ready releases the response.
  always_comb begin
    rsp_taken = grant_id ? rsp1_ready : rsp0_ready;
  end

  // Next-state decode for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_taken) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant tracking; last_grant starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      grant_id   <= winner;
      last_grant <= winner;
    end
  end

  // Latch the winner's operands on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_control <= 4'd0;
      op_shmt    <= 5'd0;
      op_data_a  <= '0;
      op_data_b  <= '0;
    end else if (accept) begin
      if (winner) begin
        op_control <= req1_control;
        op_shmt    <= req1_shmt;
        op_data_a  <= req1_dataA;
        op_data_b  <= req1_dataB;
      end else begin
        op_control <= req0_control;
        op_shmt    <= req0_shmt;
        op_data_a  <= req0_dataA;
        op_data_b  <= req0_dataB;
      end
    end
  end

  // Capture the ALU result and flags at the end of the execute cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data  <= '0;
      res_flags <= 3'd0;
    end else if (state == EXEC) begin
      res_data  <= alu_dataC;
      res_flags <= {alu_carry, alu_zero, alu_negative};
    end
  end

  // The ALU only ever sees registered operands, never the request ports.
  always_comb begin
    alu_control = op_control;
    alu_shmt    = op_shmt;
    alu_dataA   = op_data_a;
    alu_dataB   = op_data_b;
  end

  // Response outputs are presented only to the owner and read zero otherwise.
  always_comb begin
    rsp0_valid = (state == RESP) && !grant_id;
    rsp1_valid = (state == RESP) && grant_id;
    rsp0_data  = rsp0_valid ? res_data : '0;
    rsp0_flags = rsp0_valid ? res_flags : 3'd0;
    rsp1_data  = rsp1_valid ? res_data : '0;
    rsp1_flags = rsp1_valid ? res_flags : 3'd0;
    busy       = (state != IDLE);
  end

endmodule
